run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/run_ctrl.sv | 87 ++++++++
 tb/tb_run_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the run controller.
package run_ctrl_pkg;

  // Controller states: hold core in reset, strobe req, let it run, report.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RSTC = 3'd1,
    REQ  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_CW      = 16;
  localparam int DEF_TIMEOUT = 16'hFFFF;
  localparam int DEF_RST_CYC = 2;

endpackage

// File: rtl/run_ctrl.sv
// Run controller: resets a processor core, kicks it with a req strobe,
// counts run cycles until core_done or a timeout, then reports the result.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int RST_CYC = DEF_RST_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_req,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT);
  localparam logic [RW-1:0] RST_LOAD    = RW'(RST_CYC);

  state_t        state;
  logic [RW-1:0] rst_cnt;

  // Core handshake and status lines are pure decodes of the state register.
  assign core_reset = (state == IDLE) || (state == RSTC) || (state == DONE);
  assign core_req   = (state == REQ);
  assign busy       = (state != IDLE);
  assign finished   = (state == DONE);

  // Main controller FSM together with the reset-hold counter, run counter
  // and sticky timeout flag; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      cycles    <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RSTC;
            rst_cnt   <= RST_LOAD;
            cycles    <= '0;
            timed_out <= 1'b0;
          end
        end
        RSTC: begin
          // The counter is loaded with RST_CYC, so leaving when it reads 1
          // keeps the core in reset for exactly RST_CYC cycles here.
          if (rst_cnt <= RW'(1)) begin
            state   <= REQ;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        REQ: begin
          state <= RUN;
        end
        RUN: begin
          // Done beats timeout; the counter saturates at TIMEOUT.
          if (core_done) begin
            state <= DONE;
          end else if (cycles == TIMEOUT_VAL) begin
            state     <= DONE;
            timed_out <= 1'b1;
          end else begin
            cycles <= cycles + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with RST_CYC=2 and TIMEOUT=20.
module tb_run_ctrl;

  localparam int CW      = 16;
  localparam int TIMEOUT = 20;
  localparam int RST_CYC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          core_done;
  logic          core_reset;
  logic          core_req;
  logic          busy;
  logic          finished;
  logic          timed_out;
  logic [CW-1:0] cycles;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          reset;
    logic          start;
    logic          core_done;
    logic          e_core_reset;
    logic          e_core_req;
    logic          e_busy;
    logic          e_finished;
    logic          e_timed_out;
    logic [CW-1:0] e_cycles;
  } vec_t;

  vec_t vecs[$];

  run_ctrl #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT),
    .RST_CYC (RST_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .core_done  (core_done),
    .core_reset (core_reset),
    .core_req   (core_req),
    .busy       (busy),
    .finished   (finished),
    .timed_out  (timed_out),
    .cycles     (cycles)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test completed");
    $fatal(1, "[TB] watchdog");
  end

  // Drive inputs, take one clock edge, and settle just after it.
  task automatic applyStimulus(input logic r, input logic s, input logic d);
    reset     = r;
    start     = s;
    core_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_cr, input logic e_req,
                             input logic e_busy, input logic e_fin, input logic e_to,
                             input logic [CW-1:0] e_cyc);
    checks++;
    if (core_reset !== e_cr) begin
      errors++;
      $display("[TB] FAIL %s core_reset got=%b want=%b", name, core_reset, e_cr);
    end
    checks++;
    if (core_req !== e_req) begin
      errors++;
      $display("[TB] FAIL %s core_req got=%b want=%b", name, core_req, e_req);
    end
    checks++;
    if (busy !== e_busy) begin
      errors++;
      $display("[TB] FAIL %s busy got=%b want=%b", name, busy, e_busy);
    end
    checks++;
    if (finished !== e_fin) begin
      errors++;
      $display("[TB] FAIL %s finished got=%b want=%b", name, finished, e_fin);
    end
    checks++;
    if (timed_out !== e_to) begin
      errors++;
      $display("[TB] FAIL %s timed_out got=%b want=%b", name, timed_out, e_to);
    end
    checks++;
    if (cycles !== e_cyc) begin
      errors++;
      $display("[TB] FAIL %s cycles got=%0d want=%0d", name, cycles, e_cyc);
    end
  endtask

  task automatic addVec(input logic r, input logic s, input logic d,
                        input logic cr, input logic rq, input logic b,
                        input logic f, input logic t, input int c);
    vec_t v;
    v.reset = r; v.start = s; v.core_done = d;
    v.e_core_reset = cr; v.e_core_req = rq; v.e_busy = b;
    v.e_finished = f; v.e_timed_out = t; v.e_cycles = CW'(c);
    vecs.push_back(v);
  endtask

  // Start pulse from IDLE through RSTC, RSTC, REQ into the first RUN cycle.
  task automatic launch(input string tag, input logic hold_start);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput({tag, "_rstc1"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, hold_start, 1'b0);
    checkOutput({tag, "_rstc2"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, hold_start, 1'b0);
    checkOutput({tag, "_req"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, hold_start, 1'b0);
    checkOutput({tag, "_run0"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; core_done = 1'b0;

    //        rst st dn | crst req busy fin to cyc
    addVec(1, 0, 0,   1, 0, 0, 0, 0, 0);   // reset state
    addVec(0, 0, 0,   1, 0, 0, 0, 0, 0);   // idle
    addVec(0, 1, 0,   1, 0, 1, 0, 0, 0);   // accept -> RSTC
    addVec(0, 0, 0,   1, 0, 1, 0, 0, 0);   // RSTC 2nd
    addVec(0, 0, 0,   0, 1, 1, 0, 0, 0);   // REQ, 3 cycles after start
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 0);   // RUN 1
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 2);
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 3);
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 4);
    addVec(0, 0, 0,   0, 0, 1, 0, 0, 5);
    addVec(0, 0, 1,   1, 0, 1, 1, 0, 5);   // done on 6th RUN cycle
    addVec(0, 0, 0,   1, 0, 0, 0, 0, 5);   // back in IDLE, count held
    addVec(0, 1, 1,   1, 0, 1, 0, 0, 0);   // done ignored in IDLE/RSTC
    addVec(0, 0, 1,   1, 0, 1, 0, 0, 0);
    addVec(0, 0, 1,   0, 1, 1, 0, 0, 0);   // REQ still entered
    addVec(0, 0, 1,   0, 0, 1, 0, 0, 0);   // done ignored in REQ
    addVec(0, 0, 1,   1, 0, 1, 1, 0, 0);   // done in first RUN cycle
    addVec(0, 0, 0,   1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].reset, vecs[i].start, vecs[i].core_done);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_core_reset, vecs[i].e_core_req,
                  vecs[i].e_busy, vecs[i].e_finished, vecs[i].e_timed_out,
                  vecs[i].e_cycles);
    end

    // Timeout: core never finishes, counter saturates at TIMEOUT.
    launch("to", 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("to_run%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(k));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("to_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CW'(TIMEOUT));

    // Coincidence: done arrives in the cycle the counter equals TIMEOUT.
    launch("co", 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("co_at_limit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("co_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("co_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(TIMEOUT));

    // Start pulse during RUN has no effect and does not queue a new run.
    launch("sr", 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sr_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(2));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sr_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, CW'(2));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sr_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(2));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sr_stay_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(2));

    // Reset mid-run at cycles=7, with start and done also asserted.
    launch("rm", 1'b0);
    for (int k = 1; k <= 7; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rm_run7", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(7));
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rm_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rm_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Back-to-back with start held: a timed-out run, then a fresh run
    // accepted on the first IDLE cycle clears cycles and timed_out.
    launch("bb", 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bb_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bb_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CW'(TIMEOUT));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bb_accept", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bb_req", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bb_done2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bb_idle2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
